// File: rtl/tone_period_decoder.sv
// tone_period_decoder: recovers period and high time of a square-wave tone,
// declaring lock after STABLE_N matching periods and timing out to SILENT.
module tone_period_decoder #(
    parameter int CNT_W    = 16,
    parameter int STABLE_N = 4,
    parameter int TOL      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             new_tone,
    output logic             silent
);
    localparam int MW = $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {S_SILENT, S_ARMED, S_TRACK, S_LOCKED} state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, cand_q, cand_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic [MW-1:0]    mcnt_q, mcnt_d, mcnt_inc;
    logic             new_tone_q, new_tone_d;
    logic             rise, fall;
    logic [CNT_W-1:0] meas;

    function automatic logic match(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] d;
        d = a > b ? a - b : b - a;
        return d <= CNT_W'(TOL);
    endfunction

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign meas     = cnt_q + CNT_W'(1);
    assign mcnt_inc = mcnt_q + MW'(1);

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        mcnt_d     = mcnt_q;
        period_d   = period_q;
        high_d     = high_q;
        new_tone_d = 1'b0;
        cnt_d      = rise ? '0 : (cnt_q == MAX ? cnt_q : cnt_q + CNT_W'(1));
        hcnt_d     = rise ? '0 : (s3_q && hcnt_q != MAX ? hcnt_q + CNT_W'(1) : hcnt_q);
        // a rise coinciding with timeout still counts as a fresh reference edge
        if (state_q != S_SILENT && cnt_q == MAX) begin
            state_d  = rise ? S_ARMED : S_SILENT;
            period_d = '0;
            high_d   = '0;
        end else if (rise) begin
            case (state_q)
                S_SILENT: state_d = S_ARMED;
                S_ARMED: begin
                    state_d = S_TRACK;
                    cand_d  = meas;
                    mcnt_d  = MW'(1);
                end
                S_TRACK: begin
                    if (match(meas, cand_q)) begin
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc == MW'(STABLE_N)) begin
                            state_d    = S_LOCKED;
                            period_d   = cand_q;
                            new_tone_d = 1'b1;
                        end
                    end else begin
                        cand_d = meas;
                        mcnt_d = MW'(1);
                    end
                end
                S_LOCKED: begin
                    if (!match(meas, period_q)) begin
                        state_d = S_TRACK;
                        cand_d  = meas;
                        mcnt_d  = MW'(1);
                    end
                end
                default: state_d = S_SILENT;
            endcase
        end else if (fall && state_q == S_LOCKED) begin
            // hcnt_d already includes the final high cycle
            high_d = hcnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_SILENT;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            cand_q     <= '0;
            mcnt_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            new_tone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= sig_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            cand_q     <= cand_d;
            mcnt_q     <= mcnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            new_tone_q <= new_tone_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign new_tone     = new_tone_q;
    assign period_valid = state_q == S_LOCKED;
    assign silent       = state_q == S_SILENT;
endmodule

// File: tb/tb_tone_period_decoder.sv
// tb_tone_period_decoder: drives directed and randomized tone sequences and
// compares outputs with a rise-by-rise reference model of the decoder rules.
module tb_tone_period_decoder;
    localparam int TOL = 2;
    localparam int SN  = 4;

    logic        clk = 1'b0, reset = 1'b1, sig_in = 1'b0;
    logic [15:0] period, high_time;
    logic        period_valid, new_tone, silent;

    int compared = 0, mismatched = 0, nt_seen = 0;

    bit armed, locked;
    int per, ht, exp_nt, last_p;
    int run[$];

    always #5 clk = ~clk;

    tone_period_decoder dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .period(period),
        .high_time(high_time), .period_valid(period_valid),
        .new_tone(new_tone), .silent(silent)
    );

    always @(negedge clk) if (!reset && new_tone === 1'b1) nt_seen++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int absd(input int a, input int b);
        return a > b ? a - b : b - a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(period_valid), 32'(locked));
        chk({tag, "_period"}, 32'(period), per);
        chk({tag, "_high"}, 32'(high_time), ht);
        chk({tag, "_silent"}, 32'(silent), 32'(!armed));
        chk({tag, "_newtone"}, nt_seen, exp_nt);
    endtask

    // reset and timeout both return the decoder to an idle, unreferenced state
    task automatic model_idle();
        armed = 0; locked = 0; per = 0; ht = 0;
        run.delete();
    endtask

    // iv is the rise-to-rise interval ending at this rise
    task automatic model_rise(input int iv);
        if (!armed) armed = 1;
        else if (locked) begin
            if (absd(iv, per) > TOL) begin
                locked = 0;
                run = {iv};
            end
        end else begin
            if (run.size() != 0 && absd(iv, run[0]) <= TOL) run.push_back(iv);
            else run = {iv};
            if (run.size() == SN) begin
                locked = 1;
                per = run[0];
                exp_nt++;
            end
        end
    endtask

    task automatic run_period(input int p, input int h, input string tag);
        model_rise(last_p);
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        if (locked) ht = h;
        repeat (p - h) @(negedge clk);
        last_p = p;
        check_all(tag);
    endtask

    initial begin
        int jit[4] = '{98, 102, 101, 99};
        int base, p;
        model_idle();
        exp_nt = 0;
        last_p = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sig_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_newtone", 32'(new_tone), 0);
            check_all("rst");
        end
        sig_in = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_all("post_rst");

        for (int i = 0; i < 6; i++) run_period(100, 50, "lock100");
        chk("lock100_period_abs", 32'(period), 100);
        chk("lock100_high_abs", 32'(high_time), 50);
        chk("lock100_pulses", nt_seen, 1);

        foreach (jit[i]) run_period(jit[i], $urandom_range(20, jit[i] - 20), "jitter");
        chk("jitter_period_abs", 32'(period), 100);
        run_period(103, 50, "jit103");
        run_period(100, 50, "jit_drop");
        chk("jit_drop_valid_abs", 32'(period_valid), 0);
        chk("jit_drop_period_abs", 32'(period), 100);

        repeat (6) run_period(100, 50, "relock100");
        repeat (6) run_period(200, 100, "freq200");
        chk("freq200_period_abs", 32'(period), 200);
        chk("freq200_high_abs", 32'(high_time), 100);

        repeat (3) begin
            base = $urandom_range(40, 300);
            repeat (6) begin
                p = base + $urandom_range(0, 2);
                run_period(p, $urandom_range(5, p - 5), "rand_lock");
            end
            repeat (4) begin
                p = base + $urandom_range(0, 5);
                run_period(p, $urandom_range(5, p - 5), "rand_jit");
            end
        end

        repeat (6) run_period(100, 30, "pre_idle");
        chk("pre_idle_valid_abs", 32'(period_valid), 1);
        repeat (65000) @(negedge clk);
        check_all("pre_timeout");
        repeat (1000) @(negedge clk);
        model_idle();
        check_all("timeout");
        chk("timeout_silent_abs", 32'(silent), 1);
        run_period(100, 50, "rearm");
        chk("rearm_silent_abs", 32'(silent), 0);
        repeat (5) run_period(100, 50, "after_idle");

        reset = 1'b1;
        #1;
        chk("async_valid", 32'(period_valid), 0);
        chk("async_period", 32'(period), 0);
        chk("async_high", 32'(high_time), 0);
        chk("async_newtone", 32'(new_tone), 0);
        chk("async_silent", 32'(silent), 1);
        model_idle();
        @(negedge clk);
        reset = 1'b0;
        repeat (6) run_period(100, 50, "after_reset");
        chk("after_reset_period_abs", 32'(period), 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
